// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller and instruction-fetch sequencer.
// Drives pc_next into the PC register, runs the imem req/ack handshake,
// applies trap/jump/branch redirects (flushing stale fetches) and holds
// fetched words in a one-entry valid/ready slot.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap misaligned redirect
// targets to TRAP_VEC (with a misalign_err pulse) instead of forcing them aligned.
module pc_sequencer #(
    parameter int             W        = 32,
    parameter int             INSTR_W  = 32,
    parameter logic [W-1:0]   TRAP_VEC = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       pc_cur,
    output logic [W-1:0]       pc_next,
    input  logic               branch_taken,
    input  logic [W-1:0]       branch_target,
    input  logic               jump_en,
    input  logic [W-1:0]       jump_target,
    input  logic               trap_en,
    input  logic               halt,
    output logic               imem_req,
    output logic [W-1:0]       imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [W-1:0]       instr_pc,
    output logic               misalign_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DISCARD = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    logic [2:0]   state, state_nxt;
    logic [W-1:0] addr_q;     // address of the outstanding request
    logic [W-1:0] tgt_raw;    // priority-selected redirect target
    logic [W-1:0] tgt;        // target after alignment handling
    logic         redirect;
    logic         slot_free;
    logic         accept;     // ack data is written into the slot
    logic         mis;        // misaligned redirect this cycle

    assign redirect  = trap_en | jump_en | branch_taken;
    assign slot_free = !instr_valid || instr_ready;

    // Redirect target selection: trap > jump > branch, then alignment handling
    always_comb begin
        if (trap_en)
            tgt_raw = TRAP_VEC;
        else if (jump_en)
            tgt_raw = jump_target;
        else
            tgt_raw = branch_target;
`ifdef PC_MISALIGN_TRAP_EN
        mis = redirect && (tgt_raw[1:0] != 2'b00);
        tgt = (tgt_raw[1:0] != 2'b00) ? TRAP_VEC : tgt_raw;
`else
        mis = 1'b0;
        tgt = tgt_raw & ~{{(W-2){1'b0}}, 2'b11};
`endif
    end

    // Request/address outputs; the address is frozen while a request is outstanding
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_cur;
        case (state)
            S_FETCH:   imem_req = slot_free && !halt;
            S_WAIT,
            S_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
            end
            default:   imem_req = 1'b0;
        endcase
    end

    assign accept = imem_ack && !redirect &&
                    (((state == S_FETCH) && imem_req) || (state == S_WAIT));

    // Next PC: redirect beats sequential advance, otherwise hold
    always_comb begin
        if (redirect)
            pc_next = tgt;
        else if (accept)
            pc_next = pc_cur + W'(4);
        else
            pc_next = pc_cur;
    end

    // Fetch FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (!imem_req)
                    state_nxt = halt ? S_HALT : S_FETCH;
                else if (!imem_ack)
                    state_nxt = redirect ? S_DISCARD : S_WAIT;
                else
                    state_nxt = S_FETCH;
            end
            S_WAIT: begin
                if (imem_ack)
                    state_nxt = (!redirect && halt) ? S_HALT : S_FETCH;
                else if (redirect)
                    state_nxt = S_DISCARD;
            end
            S_DISCARD: begin
                // Stale response retires the old request whatever else happens
                if (imem_ack)
                    state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (!halt)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and outstanding-request address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_FETCH) && imem_req)
                addr_q <= pc_cur;
        end
    end

    // Downstream slot: flush on redirect, fill on accept, drain on ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            if (redirect)
                instr_valid <= 1'b0;
            else if (accept)
                instr_valid <= 1'b1;
            else if (instr_ready)
                instr_valid <= 1'b0;
            if (accept) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle pulse following a misaligned redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_err <= 1'b0;
        else
            misalign_err <= mis;
    end
`else
    assign misalign_err = mis;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized + directed bench for pc_sequencer against a
// program-order reference model (expected PC stream, stale-fetch tracking,
// handshake rules) with a latency-programmable memory and a PC register.
module tb_pc_sequencer;

    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur, pc_next;
    logic        branch_taken, jump_en, trap_en, halt;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, imem_ack, instr_valid, instr_ready, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target), .trap_en(trap_en),
        .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // PC register fed by pc_next
    always @(posedge clk or posedge reset)
        if (reset) pc_cur <= '0;
        else       pc_cur <= pc_next;

    int n_vec = 0, n_err = 0;

    // Reference model state
    logic [31:0] exp_pc, out_addr, acc_addr;
    logic        outst, stale, prev_acc, prev_redir, prev_mis, s_fresh;
    int          wait_cnt, cur_lat, lat_mode, deliveries;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] raw_tgt();
        return trap_en ? TV : (jump_en ? jump_target : branch_target);
    endfunction

    function automatic logic [31:0] eff_tgt();
        logic [31:0] r;
        r = raw_tgt();
`ifdef PC_MISALIGN_TRAP_EN
        return (r[1:0] != 2'b00) ? TV : r;
`else
        return {r[31:2], 2'b00};
`endif
    endfunction

    function automatic logic is_mis();
        logic [31:0] r;
        r = raw_tgt();
`ifdef PC_MISALIGN_TRAP_EN
        return (trap_en | jump_en | branch_taken) && (r[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        exp_pc = 0; out_addr = 0; acc_addr = 0;
        outst = 0; stale = 0; prev_acc = 0; prev_redir = 0; prev_mis = 0; s_fresh = 0;
        wait_cnt = 0; cur_lat = 0;
    endtask

    task automatic clear_inputs();
        branch_taken = 0; jump_en = 0; trap_en = 0; halt = 0;
        branch_target = 0; jump_target = 0; instr_ready = 1;
        imem_ack = 0; imem_rdata = 0;
    endtask

    // Memory response, then every-cycle checks and model update (before the edge)
    task automatic settle();
        logic        redir, acc;
        logic [31:0] exp_next;
        int          need;
        #1;
        need = (lat_mode >= 0) ? lat_mode : cur_lat;
        if (imem_req && wait_cnt >= need) begin
            imem_ack = 1; imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack = 0; imem_rdata = $urandom;
        end
        #1;
        redir   = trap_en | jump_en | branch_taken;
        s_fresh = imem_req && !outst;
        acc     = imem_req && imem_ack && !redir && !stale;
        if (outst) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, out_addr);
        end else if (imem_req) begin
            chk("req_legal", (!instr_valid || instr_ready) && !halt, 1);
            chk("fetch_addr", imem_addr, pc_cur);
        end
        if (prev_acc) begin
            chk("fill_valid", instr_valid, 1);
            chk("fill_pc", instr_pc, acc_addr);
            chk("fill_instr", instr, mem_word(acc_addr));
        end
        if (prev_redir) chk("flush", instr_valid, 0);
        chk("misalign", misalign_err, prev_mis);
        exp_next = redir ? eff_tgt() : (acc ? pc_cur + 32'd4 : pc_cur);
        chk("pc_next", pc_next, exp_next);
        if (instr_valid && instr_ready) begin
            chk("dlv_pc", instr_pc, exp_pc);
            chk("dlv_instr", instr, mem_word(instr_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
        end
        if (redir) exp_pc = eff_tgt();
        if (imem_req && imem_ack) stale = 0;
        else if (imem_req && redir) stale = 1;
        outst      = imem_req && !imem_ack;
        out_addr   = imem_addr;
        prev_acc   = acc;
        acc_addr   = imem_addr;
        prev_redir = redir;
        prev_mis   = is_mis();
        if (imem_req && imem_ack) begin
            wait_cnt = 0; cur_lat = $urandom_range(0, 3);
        end else if (imem_req) begin
            wait_cnt++;
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_misalign", misalign_err, 0);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_fresh(input string tag, output logic found);
        found = 0;
        for (int n = 0; n < 12; n++) begin
            settle();
            if (s_fresh) begin found = 1; break; end
            advance();
        end
        if (!found) chk(tag, 0, 1);
    endtask

    logic        found;
    logic [31:0] held_pc;

    initial begin
        reset = 1;
        clear_inputs();
        lat_mode = 0;
        deliveries = 0;

        // Zero-wait memory, back-to-back fetch stream
        do_reset();
        settle(); chk("idle_no_req", imem_req, 0); advance();
        settle(); chk("first_req", imem_req, 1); chk("first_next", pc_next, 4); advance();
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("b2b_valid", instr_valid, 1);
            chk("b2b_pc", instr_pc, 32'(4 * k));
            chk("b2b_next", pc_next, 32'(4 * (k + 2)));
            advance();
        end

        // Branch during a 3-cycle wait -> stale fetch discarded
        do_reset();
        lat_mode = 3;
        wait_fresh("first_req_timeout", found);
        advance();
        branch_taken = 1; branch_target = 32'h40;
        settle(); chk("br_next", pc_next, 32'h40); advance();
        branch_taken = 0;
        found = 0;
        for (int n = 0; n < 12; n++) begin
            settle();
            chk("stale_invalid", instr_valid, 0);
            if (s_fresh) begin chk("redir_addr", imem_addr, 32'h40); found = 1; break; end
            advance();
        end
        if (!found) chk("redir_timeout", 0, 1);
        advance();

        // Simultaneous trap/jump/branch with a full slot
        lat_mode = 0;
        repeat (4) begin settle(); advance(); end
        instr_ready = 0;
        trap_en = 1; jump_en = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40;
        settle();
        chk("pre_flush_valid", instr_valid, 1);
        chk("trap_next", pc_next, TV);
        advance();
        trap_en = 0; jump_en = 0; branch_taken = 0;
        settle(); chk("trap_flush", instr_valid, 0); advance();

        // Backpressure: full slot blocks fetch; drain allows same-cycle fetch
        repeat (3) begin settle(); advance(); end
        held_pc = pc_cur;
        settle();
        chk("bp_no_req", imem_req, 0);
        chk("bp_hold", pc_next, held_pc);
        advance();
        instr_ready = 1;
        settle();
        chk("drain_req", imem_req, 1);
        chk("drain_valid", instr_valid, 1);
        advance();

        // Wrap at top of address space, then halt mid-wait
        jump_en = 1; jump_target = 32'hFFFF_FFFC;
        settle(); advance();
        jump_en = 0;
        wait_fresh("wrap_req_timeout", found);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_next", pc_next, 0);
        lat_mode = 2;
        advance();
        settle(); chk("post_wrap_req", imem_req, 1); chk("post_wrap_addr", imem_addr, 0); advance();
        halt = 1;
        settle(); chk("halt_wait_req", imem_req, 1); advance();
        settle(); chk("halt_ack_next", pc_next, 4); advance();
        repeat (3) begin settle(); chk("halt_no_req", imem_req, 0); advance(); end
        halt = 0;

        // Misaligned redirect target
        lat_mode = 0;
        jump_en = 1; jump_target = 32'h42;
        settle();
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_next", pc_next, TV);
`else
        chk("mis_next", pc_next, 32'h40);
`endif
        advance();
        jump_en = 0;
`ifdef PC_MISALIGN_TRAP_EN
        settle(); chk("mis_pulse", misalign_err, 1); advance();
`else
        settle(); chk("mis_pulse", misalign_err, 0); advance();
`endif
        settle(); chk("mis_end", misalign_err, 0); advance();

        // Randomized traffic
        do_reset();
        lat_mode = -1;
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            instr_ready   = ($urandom_range(0, 9) < 7);
            trap_en       = ($urandom_range(0, 99) < 2);
            jump_en       = ($urandom_range(0, 99) < 4);
            branch_taken  = ($urandom_range(0, 99) < 6);
            jump_target   = ($urandom & 32'h0000_0FFC) |
                            (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            branch_target = ($urandom & 32'h0000_0FFC) |
                            (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            settle();
            advance();
        end
        chk("progress", (deliveries >= 100) ? 32'd1 : 32'd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
